// File: rtl/exc_pkg.sv
// exc_pkg: shared encodings for the exception entry/return sequencer.
//   Mode codes (5-bit, M[4]=1), source encodings, vector/LR offsets,
//   sequencer state enum and small decode helpers.
package exc_pkg;

  localparam logic [4:0] MODE_USR = 5'h10;
  localparam logic [4:0] MODE_FIQ = 5'h11;
  localparam logic [4:0] MODE_IRQ = 5'h12;
  localparam logic [4:0] MODE_SVC = 5'h13;
  localparam logic [4:0] MODE_ABT = 5'h17;
  localparam logic [4:0] MODE_UND = 5'h1B;
  localparam logic [4:0] MODE_SYS = 5'h1F;

  typedef enum logic [2:0] {
    SRC_DABT = 3'd0,
    SRC_FIQ  = 3'd1,
    SRC_IRQ  = 3'd2,
    SRC_PABT = 3'd3,
    SRC_UND  = 3'd4,
    SRC_SWI  = 3'd5,
    SRC_ERET = 3'd7
  } src_t;

  localparam logic [31:0] VOFS_UND  = 32'h04;
  localparam logic [31:0] VOFS_SWI  = 32'h08;
  localparam logic [31:0] VOFS_PABT = 32'h0C;
  localparam logic [31:0] VOFS_DABT = 32'h10;
  localparam logic [31:0] VOFS_IRQ  = 32'h18;
  localparam logic [31:0] VOFS_FIQ  = 32'h1C;

  localparam logic [31:0] LR_OFS_DABT = 32'd8;
  localparam logic [31:0] LR_OFS_STD  = 32'd4;

  localparam logic [31:0] HIVEC_BASE = 32'hFFFF_0000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SAVE,
    ST_SWITCH,
    ST_LOAD,
    ST_LINK,
    ST_RSAVE,
    ST_RSWITCH,
    ST_RLOAD,
    ST_RPC
  } state_t;

  function automatic logic [4:0] target_mode(input src_t src);
    case (src)
      SRC_DABT, SRC_PABT: target_mode = MODE_ABT;
      SRC_FIQ:            target_mode = MODE_FIQ;
      SRC_IRQ:            target_mode = MODE_IRQ;
      SRC_UND:            target_mode = MODE_UND;
      SRC_SWI:            target_mode = MODE_SVC;
      default:            target_mode = MODE_SVC;
    endcase
  endfunction

  function automatic logic [31:0] vec_ofs(input src_t src);
    case (src)
      SRC_DABT: vec_ofs = VOFS_DABT;
      SRC_FIQ:  vec_ofs = VOFS_FIQ;
      SRC_IRQ:  vec_ofs = VOFS_IRQ;
      SRC_PABT: vec_ofs = VOFS_PABT;
      SRC_UND:  vec_ofs = VOFS_UND;
      SRC_SWI:  vec_ofs = VOFS_SWI;
      default:  vec_ofs = VOFS_SWI;
    endcase
  endfunction

  function automatic logic [31:0] lr_ofs(input src_t src);
    lr_ofs = (src == SRC_DABT) ? LR_OFS_DABT : LR_OFS_STD;
  endfunction

endpackage

// File: rtl/exc_prio.sv
// exc_prio: masks irq/fiq with the CPSR I/F bits and picks the highest
//   priority pending exception (dabt > fiq > irq > pabt > und > swi).
// Ports:
//   dabt, fiq, irq, pabt, und, swi  in   level requests
//   irq_mask, fiq_mask              in   CPSR bit 7 / bit 6
//   valid                           out  some unmasked request pending
//   src                             out  winning source (SRC_DABT when !valid)
module exc_prio
  import exc_pkg::*;
(
  input  logic dabt,
  input  logic fiq,
  input  logic irq,
  input  logic pabt,
  input  logic und,
  input  logic swi,
  input  logic irq_mask,
  input  logic fiq_mask,
  output logic valid,
  output src_t src
);

  always_comb begin
    valid = 1'b1;
    src   = SRC_DABT;
    if (dabt)                  src = SRC_DABT;
    else if (fiq && !fiq_mask) src = SRC_FIQ;
    else if (irq && !irq_mask) src = SRC_IRQ;
    else if (pabt)             src = SRC_PABT;
    else if (und)              src = SRC_UND;
    else if (swi)              src = SRC_SWI;
    else                       valid = 1'b0;
  end

endmodule

// File: rtl/exc_seq.sv
// exc_seq: exception entry/return sequencer for the banked-SP/mode logic.
//   Arbitrates requests, drives the SP_out / mode switch / SP_in handshake
//   with the stack bank, writes CPSR/SPSR/LR and loads PC.
// Build option: EXC_HIVEC_EN adds the hivec input selecting the high
//   vector base 32'hFFFF_0000.
// Ports:
//   clk, rst                          clock, async active-high reset
//   hivec                             high-vector select (EXC_HIVEC_EN only)
//   dabt, fiq, irq, pabt, und, swi    exception requests (held until ack)
//   eret                              exception-return request
//   cpsr_in, spsr_in, lr_in, pc_in    current architectural state
//   ack, ack_type                     accept pulse and accepted source
//   busy                              sequence in progress
//   SP_out, SP_in, M                  stack-bank handshake and mode
//   cpsr_we/cpsr_o, spsr_we/spsr_o,
//   lr_we/lr_o, pc_we/pc_o            register write strobes and data
//
// state      | meaning
// ST_IDLE    | arbitrate; M follows cpsr_in
// ST_SAVE    | SP_out pulse in old mode
// ST_SWITCH  | write CPSR/SPSR, M = new mode
// ST_LOAD    | SP_in pulse in new mode
// ST_LINK    | write LR and vector PC
// ST_RSAVE   | return: SP_out pulse in current mode
// ST_RSWITCH | return: CPSR <= saved SPSR
// ST_RLOAD   | return: SP_in pulse in restored mode
// ST_RPC     | return: PC <= saved LR
module exc_seq
  import exc_pkg::*;
#(
  parameter logic [31:0] VEC_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
`ifdef EXC_HIVEC_EN
  input  logic        hivec,
`endif
  input  logic        dabt,
  input  logic        fiq,
  input  logic        irq,
  input  logic        pabt,
  input  logic        und,
  input  logic        swi,
  input  logic        eret,
  input  logic [31:0] cpsr_in,
  input  logic [31:0] spsr_in,
  input  logic [31:0] lr_in,
  input  logic [31:0] pc_in,
  output logic        ack,
  output logic [2:0]  ack_type,
  output logic        busy,
  output logic        SP_out,
  output logic        SP_in,
  output logic [4:0]  M,
  output logic        cpsr_we,
  output logic [31:0] cpsr_o,
  output logic        spsr_we,
  output logic [31:0] spsr_o,
  output logic        lr_we,
  output logic [31:0] lr_o,
  output logic        pc_we,
  output logic [31:0] pc_o
);

  state_t      state;
  src_t        src_l;
  logic [31:0] cpsr_l, pc_l, lr_l, spsr_l;

  logic        exc_valid;
  src_t        exc_src;
  logic        eret_ok;
  logic [31:0] vec_base;
  logic [4:0]  new_mode;
  logic [31:0] entry_cpsr;

  exc_prio u_prio (
    .dabt     (dabt),
    .fiq      (fiq),
    .irq      (irq),
    .pabt     (pabt),
    .und      (und),
    .swi      (swi),
    .irq_mask (cpsr_in[7]),
    .fiq_mask (cpsr_in[6]),
    .valid    (exc_valid),
    .src      (exc_src)
  );

  // usr and sys share the user register bank, so there is no SPSR to return from
  assign eret_ok = eret && (cpsr_in[3:0] != 4'h0) && (cpsr_in[3:0] != 4'hF);

`ifdef EXC_HIVEC_EN
  assign vec_base = hivec ? HIVEC_BASE : VEC_BASE;
`else
  assign vec_base = VEC_BASE;
`endif

  assign new_mode   = target_mode(src_l);
  // I always set, F set only on fiq entry, T cleared
  assign entry_cpsr = {cpsr_l[31:8], 1'b1, (src_l == SRC_FIQ) ? 1'b1 : cpsr_l[6],
                       1'b0, new_mode};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      src_l    <= SRC_DABT;
      cpsr_l   <= '0;
      pc_l     <= '0;
      lr_l     <= '0;
      spsr_l   <= '0;
      ack      <= 1'b0;
      ack_type <= '0;
      busy     <= 1'b0;
      SP_out   <= 1'b0;
      SP_in    <= 1'b0;
      M        <= MODE_USR;
      cpsr_we  <= 1'b0;
      cpsr_o   <= '0;
      spsr_we  <= 1'b0;
      spsr_o   <= '0;
      lr_we    <= 1'b0;
      lr_o     <= '0;
      pc_we    <= 1'b0;
      pc_o     <= '0;
    end else begin
      ack     <= 1'b0;
      SP_out  <= 1'b0;
      SP_in   <= 1'b0;
      cpsr_we <= 1'b0;
      spsr_we <= 1'b0;
      lr_we   <= 1'b0;
      pc_we   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          M <= cpsr_in[4:0];
          if (exc_valid || eret_ok) begin
            src_l    <= exc_valid ? exc_src : SRC_ERET;
            ack_type <= exc_valid ? exc_src : SRC_ERET;
            cpsr_l   <= cpsr_in;
            pc_l     <= pc_in;
            lr_l     <= lr_in;
            spsr_l   <= spsr_in;
            ack      <= 1'b1;
            busy     <= 1'b1;
            SP_out   <= 1'b1;
            state    <= exc_valid ? ST_SAVE : ST_RSAVE;
          end
        end
        ST_SAVE: begin
          cpsr_we <= 1'b1;
          cpsr_o  <= entry_cpsr;
          spsr_we <= 1'b1;
          spsr_o  <= cpsr_l;
          M       <= new_mode;
          state   <= ST_SWITCH;
        end
        ST_SWITCH: begin
          SP_in <= 1'b1;
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          lr_we <= 1'b1;
          lr_o  <= pc_l + lr_ofs(src_l);
          pc_we <= 1'b1;
          pc_o  <= vec_base + vec_ofs(src_l);
          state <= ST_LINK;
        end
        ST_LINK: begin
          busy  <= 1'b0;
          M     <= cpsr_in[4:0];
          state <= ST_IDLE;
        end
        ST_RSAVE: begin
          cpsr_we <= 1'b1;
          cpsr_o  <= spsr_l;
          M       <= spsr_l[4:0];
          state   <= ST_RSWITCH;
        end
        ST_RSWITCH: begin
          SP_in <= 1'b1;
          state <= ST_RLOAD;
        end
        ST_RLOAD: begin
          pc_we <= 1'b1;
          pc_o  <= lr_l;
          state <= ST_RPC;
        end
        ST_RPC: begin
          busy  <= 1'b0;
          M     <= cpsr_in[4:0];
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_seq.sv
// tb_exc_seq: directed self-checking bench for exc_seq.
module tb_exc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        dabt, fiq, irq, pabt, und, swi, eret;
  logic [31:0] cpsr_in, spsr_in, lr_in, pc_in;
  logic        ack, busy, SP_out, SP_in;
  logic [2:0]  ack_type;
  logic [4:0]  M;
  logic        cpsr_we, spsr_we, lr_we, pc_we;
  logic [31:0] cpsr_o, spsr_o, lr_o, pc_o;
`ifdef EXC_HIVEC_EN
  logic        hivec;
  localparam logic [31:0] DABT_BASE = 32'hFFFF_0000;
`else
  localparam logic [31:0] DABT_BASE = 32'h0000_0000;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  exc_seq dut (
    .clk      (clk),
    .rst      (rst),
`ifdef EXC_HIVEC_EN
    .hivec    (hivec),
`endif
    .dabt     (dabt),
    .fiq      (fiq),
    .irq      (irq),
    .pabt     (pabt),
    .und      (und),
    .swi      (swi),
    .eret     (eret),
    .cpsr_in  (cpsr_in),
    .spsr_in  (spsr_in),
    .lr_in    (lr_in),
    .pc_in    (pc_in),
    .ack      (ack),
    .ack_type (ack_type),
    .busy     (busy),
    .SP_out   (SP_out),
    .SP_in    (SP_in),
    .M        (M),
    .cpsr_we  (cpsr_we),
    .cpsr_o   (cpsr_o),
    .spsr_we  (spsr_we),
    .spsr_o   (spsr_o),
    .lr_we    (lr_we),
    .lr_o     (lr_o),
    .pc_we    (pc_we),
    .pc_o     (pc_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req();
    dabt = 0; fiq = 0; irq = 0; pabt = 0; und = 0; swi = 0; eret = 0;
  endtask

  task automatic wait_ack(input string name, output bit seen);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check({name, "_ack_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic no_ack(input string name, input int cycles);
    int n_ack  = 0;
    int n_busy = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (ack)  n_ack++;
      if (busy) n_busy++;
    end
    check({name, "_ack_cnt"}, n_ack, 0);
    check({name, "_busy_cnt"}, n_busy, 0);
  endtask

  task automatic entry_seq(input string name, input logic [2:0] typ,
                           input logic [4:0] m_old, input logic [4:0] m_new,
                           input logic [31:0] cpsr_e, input logic [31:0] spsr_e,
                           input logic [31:0] lr_e, input logic [31:0] pc_e);
    bit seen;
    wait_ack(name, seen);
    if (!seen) return;
    clr_req();
    check({name, "_ack_type"}, ack_type, typ);
    check({name, "_save_spout"}, SP_out, 1);
    check({name, "_save_M"}, M, m_old);
    check({name, "_save_busy"}, busy, 1);
    tick();
    check({name, "_sw_ack"}, ack, 0);
    check({name, "_sw_spout"}, SP_out, 0);
    check({name, "_sw_cpsr_we"}, cpsr_we, 1);
    check({name, "_sw_cpsr_o"}, cpsr_o, cpsr_e);
    check({name, "_sw_spsr_we"}, spsr_we, 1);
    check({name, "_sw_spsr_o"}, spsr_o, spsr_e);
    check({name, "_sw_M"}, M, m_new);
    tick();
    check({name, "_ld_spin"}, SP_in, 1);
    check({name, "_ld_M"}, M, m_new);
    check({name, "_ld_cpsr_we"}, cpsr_we, 0);
    tick();
    check({name, "_lk_spin"}, SP_in, 0);
    check({name, "_lk_lr_we"}, lr_we, 1);
    check({name, "_lk_lr_o"}, lr_o, lr_e);
    check({name, "_lk_pc_we"}, pc_we, 1);
    check({name, "_lk_pc_o"}, pc_o, pc_e);
    check({name, "_lk_busy"}, busy, 1);
    tick();
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_idle_pc_we"}, pc_we, 0);
  endtask

  task automatic return_seq(input string name, input logic [4:0] m_cur,
                            input logic [31:0] spsr_e, input logic [31:0] pc_e);
    bit seen;
    wait_ack(name, seen);
    if (!seen) return;
    clr_req();
    check({name, "_ack_type"}, ack_type, 7);
    check({name, "_rsave_spout"}, SP_out, 1);
    check({name, "_rsave_M"}, M, m_cur);
    tick();
    check({name, "_rsw_cpsr_we"}, cpsr_we, 1);
    check({name, "_rsw_cpsr_o"}, cpsr_o, spsr_e);
    check({name, "_rsw_spsr_we"}, spsr_we, 0);
    check({name, "_rsw_M"}, M, spsr_e[4:0]);
    tick();
    check({name, "_rld_spin"}, SP_in, 1);
    check({name, "_rld_M"}, M, spsr_e[4:0]);
    tick();
    check({name, "_rpc_pc_we"}, pc_we, 1);
    check({name, "_rpc_pc_o"}, pc_o, pc_e);
    check({name, "_rpc_lr_we"}, lr_we, 0);
    check({name, "_rpc_busy"}, busy, 1);
    tick();
    check({name, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int n_spin;
    bit seen;
    clr_req();
    cpsr_in = 32'h10; spsr_in = 0; lr_in = 0; pc_in = 0;
`ifdef EXC_HIVEC_EN
    hivec = 0;
`endif
    rst = 1;
    tick(); tick();
    check("rst_M", M, 32'h10);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_spout", SP_out, 0);
    check("rst_pc_o", pc_o, 0);
    rst = 0;
    tick();

    // irq from usr
    cpsr_in = 32'h10; pc_in = 32'h100; irq = 1;
    entry_seq("irq_usr", 3'd2, 5'h10, 5'h12, 32'h92, 32'h10, 32'h104, 32'h18);

    // fiq beats irq
    cpsr_in = 32'h10; pc_in = 32'h100; irq = 1; fiq = 1;
    entry_seq("fiq_irq", 3'd1, 5'h10, 5'h11, 32'hD1, 32'h10, 32'h104, 32'h1C);

    // masked irq, then swi taken
    cpsr_in = 32'h90; pc_in = 32'h400; irq = 1;
    no_ack("irq_masked", 20);
    swi = 1;
    entry_seq("swi_masked", 3'd5, 5'h10, 5'h13, 32'h93, 32'h90, 32'h404, 32'h08);

    // eret from irq mode
    cpsr_in = 32'h92; spsr_in = 32'h10; lr_in = 32'h104; eret = 1;
    return_seq("eret_irq", 5'h12, 32'h10, 32'h104);

    // eret from usr / sys never acked
    cpsr_in = 32'h10; eret = 1;
    no_ack("eret_usr", 20);
    cpsr_in = 32'h1F;
    no_ack("eret_sys", 10);
    clr_req();

    // und beats eret in irq mode (irq masked there)
    cpsr_in = 32'h92; spsr_in = 32'h10; lr_in = 32'h104; pc_in = 32'h500;
    und = 1; eret = 1; irq = 1;
    entry_seq("und_eret", 3'd4, 5'h12, 5'h1B, 32'h9B, 32'h92, 32'h504, 32'h04);

    // dabt over pabt, LR offset 8
    cpsr_in = 32'h10; pc_in = 32'h200; dabt = 1; pabt = 1;
`ifdef EXC_HIVEC_EN
    hivec = 1;
`endif
    entry_seq("dabt", 3'd0, 5'h10, 5'h17, 32'h97, 32'h10, 32'h208, DABT_BASE + 32'h10);
`ifdef EXC_HIVEC_EN
    hivec = 0;
`endif

    // pabt with fiq masked
    cpsr_in = 32'h50; pc_in = 32'hFFFF_FFFC; pabt = 1; fiq = 1;
    entry_seq("pabt_wrap", 3'd3, 5'h10, 5'h17, 32'hD7, 32'h50, 32'h0, 32'h0C);

    // reset during SWITCH
    cpsr_in = 32'h10; pc_in = 32'h100; irq = 1;
    wait_ack("rst_mid", seen);
    clr_req();
    tick();
    check("rst_mid_sw_cpsr_we", cpsr_we, 1);
    rst = 1;
    #1;
    check("rst_mid_cpsr_we", cpsr_we, 0);
    check("rst_mid_M", M, 32'h10);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_cpsr_o", cpsr_o, 0);
    tick(); tick();
    rst = 0;
    n_spin = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (SP_in || busy || ack) n_spin++;
    end
    check("rst_mid_no_resume", n_spin, 0);
    irq = 1;
    entry_seq("post_rst", 3'd2, 5'h10, 5'h12, 32'h92, 32'h10, 32'h104, 32'h18);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exc_seq.md
# exc_seq

Exception entry/return sequencer for the CPU's banked-SP and mode logic. Arbitrates pending exception requests against CPSR masks and picks the highest-priority one. Drives the stack-bank handshake: SP_out pulse in the old mode, mode switch, SP_in pulse in the new mode. Writes CPSR/SPSR/LR and loads the vector PC; runs the mirror sequence for exception return.

## Interface
- VEC_BASE, 32'h0000_0000, low vector base address
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- dabt, fiq, irq, pabt, und, swi  in  1 each  level requests; requester holds each request until ack
- eret  in  1  exception-return request, level until ack
- cpsr_in  in  32  current CPSR
- spsr_in  in  32  SPSR of current mode
- lr_in  in  32  LR of current mode
- pc_in  in  32  address of current instruction
- ack  out  1  one-cycle pulse when a request is accepted
- ack_type  out  3  accepted source, valid with ack: 0 dabt, 1 fiq, 2 irq, 3 pabt, 4 und, 5 swi, 7 eret
- busy  out  1  sequence in progress
- SP_out, SP_in  out  1  stack-bank pulses
- M  out  5  mode presented to the stack bank
- cpsr_we/cpsr_o, spsr_we/spsr_o, lr_we/lr_o, pc_we/pc_o  out  1/32 each  register write strobes and data

## Operation
- Mode codes (M[4]=1), M[3:0]: usr 0, fiq 1, irq 2, svc 3, abt 7, und 11, sys 15.
- Target modes:
  - dabt, pabt → abt
  - fiq → fiq
  - irq → irq
  - und → und
  - swi → svc
- Vector offsets: und 0x04, swi 0x08, pabt 0x0C, dabt 0x10, irq 0x18, fiq 0x1C.
- LR = pc_in + ofs, modulo 2^32. ofs is 8 for dabt and 4 for all others.
- Priority: dabt > fiq > irq > pabt > und > swi.
- Masking: irq is masked by cpsr_in[7]; fiq is masked by cpsr_in[6]. Masked requests are not acked.
- In IDLE, any unmasked exception beats eret. eret is accepted only when cpsr_in[3:0] is not usr or sys. Otherwise eret is never acked.
- Acceptance latches: type, old CPSR, pc_in, lr_in, spsr_in.
- Entry states:
  - IDLE → SAVE (SP_out=1, M=old mode)
  - SAVE → SWITCH (cpsr_we, spsr_we, M=new mode)
  - SWITCH → LOAD (SP_in=1, M=new mode)
  - LOAD → LINK (lr_we, pc_we)
  - LINK → IDLE
- Entry data:
  - cpsr_o = old CPSR with [4:0]=new mode, bit7=1, bit6=1 if fiq else unchanged, bit5=0
  - spsr_o = old CPSR
  - pc_o = base + vector offset
- Return states:
  - IDLE → RSAVE (SP_out=1, M=current mode)
  - RSAVE → RSWITCH (cpsr_we, cpsr_o = latched spsr, M=spsr[4:0])
  - RSWITCH → RLOAD (SP_in=1, M=spsr[4:0])
  - RLOAD → RPC (pc_we, pc_o = latched lr_in)
  - RPC → IDLE
- In IDLE, M = cpsr_in[4:0] and all strobes are 0.
- Requests arriving while busy are ignored. They are re-arbitrated in IDLE against the updated cpsr_in.

## Timing
- ack and ack_type are registered: they are high for one cycle, the cycle after the accepting IDLE cycle. That same cycle is SAVE/RSAVE.
- busy is high from SAVE/RSAVE through LINK/RPC: 4 cycles.
- A new accept can occur in the first IDLE cycle after LINK/RPC.
- All strobes are single-cycle and registered. SP_out and SP_in are never high in the same cycle.
- Reset:
  - All outputs 0, except M = 5'b10000.
  - State returns to IDLE and latches clear.
  - Reset mid-sequence emits no further strobes; a partial sequence is not resumed.

## Configuration
- EXC_HIVEC_EN defined:
  - Adds input port hivec (1 bit).
  - Vector base is 32'hFFFF_0000 when hivec=1, else VEC_BASE.
- EXC_HIVEC_EN undefined: no hivec port; base is always VEC_BASE.

## Structure
- Package exc_pkg holds:
  - mode codes
  - source encodings
  - vector-offset and LR-offset constants
  - state enum
- Sub-module exc_prio: combinational mask and priority encoder producing a valid flag and the source.

## Test plan
- IRQ from usr (cpsr_in=0x10, pc_in=0x100):
  - SAVE: SP_out with M=0x10.
  - SWITCH: cpsr_o=0x92, spsr_o=0x10.
  - LOAD: SP_in with M=0x12.
  - LINK: lr_o=0x104, pc_o=0x18.
- irq+fiq together, cpsr 0x10 → ack_type=1, cpsr_o=0xD1, M=0x11, pc_o=0x1C.
- irq with cpsr_in=0x90 → no ack for 20 cycles, busy stays 0. Adding swi → swi taken, pc_o=0x08, M=0x13.
- eret in irq mode (cpsr 0x92, spsr 0x10, lr 0x104):
  - RSAVE: SP_out with M=0x12.
  - RSWITCH: cpsr_o=0x10.
  - RLOAD: SP_in with M=0x10.
  - RPC: pc_o=0x104.
  - Separately, eret with cpsr 0x10 is never acked.
- rst asserted during SWITCH → outputs zero immediately, no SP_in follows, IDLE after release.
- With EXC_HIVEC_EN, hivec=1, dabt at pc_in=0x200 → pc_o=0xFFFF0010, lr_o=0x208.
